// File: rtl/lsu_access_splitter.sv
`default_nettype none
// ============================================================================
// Module  : lsu_access_splitter
// Brief   : Splits a load/store into one or two word-aligned TCM transactions
//           and merges/extends the returned load data.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_access_splitter #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_we_i,
    input  logic [1:0]            req_type_i,
    input  logic                  req_sign_ext_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE_LO = 3'd1,
        S_WAIT_LO  = 3'd2,
        S_ISSUE_HI = 3'd3,
        S_WAIT_HI  = 3'd4,
        S_RESP     = 3'd5,
        S_ERR      = 3'd6
    } state_t;

    localparam logic [1:0] c_type_byte = 2'b00;
    localparam logic [1:0] c_type_half = 2'b01;
    localparam logic [1:0] c_type_ill  = 2'b11;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_we;
    logic [1:0]              r_type;
    logic                    r_sign_ext;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_lo;
    logic [DATA_WIDTH-1:0]   r_hi;

    logic                    w_accept;
    logic [1:0]              w_off;
    logic [7:0]              w_be8;
    logic [63:0]             w_wd64;
    logic                    w_split;
    logic [ADDR_WIDTH-3:0]   w_word;
    logic [ADDR_WIDTH-3:0]   w_word_nxt;
    logic [31:0]             w_rd;
    logic [31:0]             w_rd_ext;

    function automatic logic [7:0] f_be8(input logic [1:0] typ, input logic [1:0] off);
        logic [3:0] m;
        case (typ)
            c_type_byte: m = 4'b0001;
            c_type_half: m = 4'b0011;
            default:     m = 4'b1111;
        endcase
        return {4'b0000, m} << off;
    endfunction

    function automatic logic f_split(input logic [1:0] typ, input logic [1:0] off);
        logic [7:0] be;
        be = f_be8(typ, off);
        return |be[7:4];
    endfunction

    assign w_accept   = req_valid_i && (r_state == S_IDLE);
    assign w_off      = r_addr[1:0];
    assign w_be8      = f_be8(r_type, w_off);
    assign w_wd64     = {{DATA_WIDTH{1'b0}}, r_wdata} << {w_off, 3'b000};
    assign w_split    = |w_be8[7:4];
    assign w_word     = r_addr[ADDR_WIDTH-1:2];
    // Natural overflow gives the required wrap from the top word to address 0.
    assign w_word_nxt = w_word + {{(ADDR_WIDTH-3){1'b0}}, 1'b1};
    assign w_rd       = 32'({r_hi, r_lo} >> {w_off, 3'b000});

    always_comb begin
        w_rd_ext = w_rd;
        case (r_type)
            c_type_byte: w_rd_ext = {{24{r_sign_ext & w_rd[7]}}, w_rd[7:0]};
            c_type_half: w_rd_ext = {{16{r_sign_ext & w_rd[15]}}, w_rd[15:0]};
            default:     w_rd_ext = w_rd;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_type     <= 2'b00;
            r_sign_ext <= 1'b0;
            r_wdata    <= '0;
            r_lo       <= '0;
            r_hi       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr     <= req_addr_i;
                r_we       <= req_we_i;
                r_type     <= req_type_i;
                r_sign_ext <= req_sign_ext_i;
                r_wdata    <= req_wdata_i;
                r_lo       <= '0;
                r_hi       <= '0;
            end
            if (r_state == S_WAIT_LO && mem_rvalid_i) r_lo <= mem_rdata_i;
            if (r_state == S_WAIT_HI && mem_rvalid_i) r_hi <= mem_rdata_i;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'b0000;
        mem_wdata_o = '0;
        rsp_valid_o = 1'b0;
        rsp_rdata_o = '0;
        rsp_err_o   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (req_type_i == c_type_ill ||
                        (f_split(req_type_i, req_addr_i[1:0]) && ALLOW_MISALIGNED == 0))
                        w_state_nxt = S_ERR;
                    else
                        w_state_nxt = S_ISSUE_LO;
                end
            end
            S_ISSUE_LO: begin
                mem_req_o   = 1'b1;
                mem_addr_o  = {w_word, 2'b00};
                mem_we_o    = r_we;
                mem_be_o    = w_be8[3:0];
                mem_wdata_o = w_wd64[31:0];
                if (mem_gnt_i) w_state_nxt = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (mem_rvalid_i) w_state_nxt = w_split ? S_ISSUE_HI : S_RESP;
            end
            S_ISSUE_HI: begin
                mem_req_o   = 1'b1;
                mem_addr_o  = {w_word_nxt, 2'b00};
                mem_we_o    = r_we;
                mem_be_o    = w_be8[7:4];
                mem_wdata_o = w_wd64[63:32];
                if (mem_gnt_i) w_state_nxt = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (mem_rvalid_i) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_rdata_o = r_we ? '0 : w_rd_ext;
                if (rsp_ready_i) w_state_nxt = S_IDLE;
            end
            S_ERR: begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = 1'b1;
                if (rsp_ready_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_access_splitter.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_access_splitter
// Brief   : Directed self-checking bench for lsu_access_splitter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lsu_access_splitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_valid_na = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_type_i = 2'b00;
    logic        req_sign_ext_i = 1'b0;
    logic [31:0] req_wdata_i = '0;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        rsp_ready_i = 1'b0;

    logic        req_ready_o, mem_req_o, mem_we_o, rsp_valid_o, rsp_err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, rsp_rdata_o;
    logic [3:0]  mem_be_o;

    logic        na_req_ready, na_mem_req, na_mem_we, na_rsp_valid, na_rsp_err;
    logic [31:0] na_mem_addr, na_mem_wdata, na_rsp_rdata;
    logic [3:0]  na_mem_be;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    lsu_access_splitter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ALLOW_MISALIGNED(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_we_i(req_we_i), .req_type_i(req_type_i), .req_sign_ext_i(req_sign_ext_i),
        .req_wdata_i(req_wdata_i),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
    );

    lsu_access_splitter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ALLOW_MISALIGNED(0)) u_dut_na (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_na), .req_ready_o(na_req_ready), .req_addr_i(req_addr_i),
        .req_we_i(req_we_i), .req_type_i(req_type_i), .req_sign_ext_i(req_sign_ext_i),
        .req_wdata_i(req_wdata_i),
        .mem_req_o(na_mem_req), .mem_gnt_i(mem_gnt_i), .mem_addr_o(na_mem_addr),
        .mem_we_o(na_mem_we), .mem_be_o(na_mem_be), .mem_wdata_o(na_mem_wdata),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .rsp_valid_o(na_rsp_valid), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(na_rsp_rdata), .rsp_err_o(na_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_access(
        input string tag, input logic we, input logic [1:0] typ, input logic sx,
        input logic [31:0] addr, input logic [31:0] wdata,
        input logic [31:0] lo, input logic [31:0] hi, input logic split,
        input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] wd1,
        input logic [31:0] a2, input logic [3:0] be2, input logic [31:0] wd2,
        input logic [31:0] rsp, input int gstall, input int rstall);
        check({tag, ".rdy_in"}, req_ready_o, 1'b1);
        req_valid_i = 1'b1; req_we_i = we; req_type_i = typ;
        req_sign_ext_i = sx; req_addr_i = addr; req_wdata_i = wdata;
        step();
        req_valid_i = 1'b0; req_addr_i = 32'h5555_5555; req_wdata_i = 32'h0;
        for (int i = 0; i < gstall; i++) begin
            check({tag, ".stall_req"}, mem_req_o, 1'b1);
            check({tag, ".stall_a1"}, mem_addr_o, a1);
            check({tag, ".stall_rdy"}, req_ready_o, 1'b0);
            step();
        end
        check({tag, ".req1"}, mem_req_o, 1'b1);
        check({tag, ".a1"}, mem_addr_o, a1);
        check({tag, ".be1"}, mem_be_o, be1);
        check({tag, ".wd1"}, mem_wdata_o, wd1);
        check({tag, ".we1"}, mem_we_o, we);
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        check({tag, ".wait_req"}, mem_req_o, 1'b0);
        check({tag, ".wait_rsp"}, rsp_valid_o, 1'b0);
        mem_rvalid_i = 1'b1; mem_rdata_i = lo;
        step();
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'hA5A5_A5A5;
        if (split) begin
            check({tag, ".req2"}, mem_req_o, 1'b1);
            check({tag, ".a2"}, mem_addr_o, a2);
            check({tag, ".be2"}, mem_be_o, be2);
            check({tag, ".wd2"}, mem_wdata_o, wd2);
            mem_gnt_i = 1'b1;
            step();
            mem_gnt_i = 1'b0;
            mem_rvalid_i = 1'b1; mem_rdata_i = hi;
            step();
            mem_rvalid_i = 1'b0; mem_rdata_i = 32'hA5A5_A5A5;
        end
        for (int i = 0; i < rstall; i++) begin
            check({tag, ".hold_vld"}, rsp_valid_o, 1'b1);
            check({tag, ".hold_data"}, rsp_rdata_o, rsp);
            check({tag, ".hold_rdy"}, req_ready_o, 1'b0);
            step();
        end
        check({tag, ".rsp_vld"}, rsp_valid_o, 1'b1);
        check({tag, ".rsp_data"}, rsp_rdata_o, rsp);
        check({tag, ".rsp_err"}, rsp_err_o, 1'b0);
        check({tag, ".rsp_mreq"}, mem_req_o, 1'b0);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        check({tag, ".done_vld"}, rsp_valid_o, 1'b0);
        check({tag, ".done_rdy"}, req_ready_o, 1'b1);
    endtask

    task automatic run_err(input string tag, input logic na, input logic [1:0] typ,
                           input logic [31:0] addr);
        req_type_i = typ; req_addr_i = addr; req_we_i = 1'b0; req_sign_ext_i = 1'b0;
        if (na) req_valid_na = 1'b1; else req_valid_i = 1'b1;
        step();
        req_valid_na = 1'b0; req_valid_i = 1'b0;
        check({tag, ".mreq"}, na ? na_mem_req : mem_req_o, 1'b0);
        check({tag, ".vld"}, na ? na_rsp_valid : rsp_valid_o, 1'b1);
        check({tag, ".err"}, na ? na_rsp_err : rsp_err_o, 1'b1);
        check({tag, ".data"}, na ? na_rsp_rdata : rsp_rdata_o, 32'h0);
        step();
        check({tag, ".hold_mreq"}, na ? na_mem_req : mem_req_o, 1'b0);
        check({tag, ".hold_err"}, na ? na_rsp_err : rsp_err_o, 1'b1);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        check({tag, ".done_vld"}, na ? na_rsp_valid : rsp_valid_o, 1'b0);
        check({tag, ".done_rdy"}, na ? na_req_ready : req_ready_o, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step();
        check("rst.rdy", req_ready_o, 1'b1);
        check("rst.mreq", mem_req_o, 1'b0);
        check("rst.be", mem_be_o, 4'h0);
        check("rst.vld", rsp_valid_o, 1'b0);
        check("rst.err", rsp_err_o, 1'b0);
        check("rst.data", rsp_rdata_o, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        run_access("lw_aligned", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0,
                   32'h100, 4'b1111, 32'h0, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 0, 0);
        run_access("lb_signed", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h8000_0000, 32'h0, 1'b0,
                   32'h100, 4'b1000, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFF_FF80, 0, 0);
        run_access("lb_unsigned", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h8000_0000, 32'h0, 1'b0,
                   32'h100, 4'b1000, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0000_0080, 0, 0);
        run_access("lb_pos", 1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 32'h0055_0000, 32'h0, 1'b0,
                   32'h100, 4'b0100, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0000_0055, 0, 0);
        run_access("sw_split", 1'b1, 2'b10, 1'b0, 32'h102, 32'hAABBCCDD, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1,
                   32'h100, 4'b1100, 32'hCCDD_0000, 32'h104, 4'b0011, 32'h0000_AABB, 32'h0, 0, 0);
        run_access("sb_lane1", 1'b1, 2'b00, 1'b0, 32'h101, 32'h1234_56EE, 32'h0, 32'h0, 1'b0,
                   32'h100, 4'b0010, 32'h3456_EE00, 32'h0, 4'h0, 32'h0, 32'h0, 0, 0);
        run_access("lh_wrap", 1'b0, 2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h7F00_0000, 32'h0000_00FF, 1'b1,
                   32'hFFFF_FFFC, 4'b1000, 32'h0, 32'h0000_0000, 4'b0001, 32'h0, 32'hFFFF_FF7F, 0, 0);
        run_access("lh_stall", 1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'h00AB_CD00, 32'h0, 1'b0,
                   32'h100, 4'b0110, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0000_ABCD, 3, 2);

        run_err("type11", 1'b0, 2'b11, 32'h200);
        run_err("na_lw_mis", 1'b1, 2'b10, 32'h102);

        // Reset while waiting for the first read word.
        req_valid_i = 1'b1; req_type_i = 2'b10; req_addr_i = 32'h200; req_we_i = 1'b0;
        step();
        req_valid_i = 1'b0;
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rstmid.mreq", mem_req_o, 1'b0);
        check("rstmid.rdy", req_ready_o, 1'b1);
        check("rstmid.vld", rsp_valid_o, 1'b0);
        step();
        rst_n = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_2222;
        step();
        mem_rvalid_i = 1'b0;
        step();
        check("rstmid.after_vld", rsp_valid_o, 1'b0);
        check("rstmid.after_mreq", mem_req_o, 1'b0);

        run_access("lw_post_rst", 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'hCAFE_F00D, 32'h0, 1'b0,
                   32'h300, 4'b1111, 32'h0, 32'h0, 4'h0, 32'h0, 32'hCAFE_F00D, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
